core_status: RTL and testbench

Processor status (P) register and interrupt-request logic for the 2A03 core. It sits directly downstream of the ALU: it captures the ALU's C/Z/V/N results under the ALU's flag mask and feeds the current flags back as the ALU's flag inputs. It also applies the flag instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED), PLP/RTI loads and PHP/BRK push formatting. It detects NMI edges and IRQ levels and presents a gated interrupt request to the sequencer at each instruction poll point.

---
 rtl/core_status.sv | 131 +++++++++++++
 tb/tb_core_status.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/core_status.sv
// 2A03 processor status register with NMI edge / IRQ level request logic.
// Define CORE_IRQ_DELAY_EN to gate IRQs on the pre-update I flag (6502 one-instruction delay).
module core_status (
    input  logic       I_clock,
    input  logic       I_reset_n,
    input  logic       I_enable,
    input  logic       I_alu_carry,
    input  logic       I_alu_zero,
    input  logic       I_alu_overflow,
    input  logic       I_alu_sign,
    input  logic [3:0] I_alu_mask,
    input  logic [2:0] I_flag_op,
    input  logic       I_load_p,
    input  logic [7:0] I_data,
    input  logic       I_set_i,
    input  logic       I_brk,
    input  logic       I_nmi_n,
    input  logic       I_irq_n,
    input  logic       I_poll,
    input  logic       I_int_ack,
    output logic [7:0] O_p,
    output logic [7:0] O_push_data,
    output logic       O_carry,
    output logic       O_zero,
    output logic       O_overflow,
    output logic       O_sign,
    output logic       O_int_request,
    output logic       O_int_is_nmi
);

    logic flag_c, flag_z, flag_i, flag_d, flag_v, flag_n;
    logic c_next, z_next, i_next, d_next, v_next, n_next;
    logic nmi_prev, nmi_pending, irq_level, int_request, int_is_nmi;
    logic i_gate, poll_ok, take_nmi, take_irq, nmi_fell;
    logic unused_data_bits;

    // B and the constant bit are never stored; a pulled byte's bits 5/4 are dropped.
    assign unused_data_bits = ^I_data[5:4];

    always_comb begin
        c_next = flag_c;
        z_next = flag_z;
        i_next = flag_i;
        d_next = flag_d;
        v_next = flag_v;
        n_next = flag_n;
        if (I_load_p) begin
            c_next = I_data[0];
            z_next = I_data[1];
            i_next = I_data[2];
            d_next = I_data[3];
            v_next = I_data[6];
            n_next = I_data[7];
        end else begin
            if (I_alu_mask[0]) c_next = I_alu_carry;
            if (I_alu_mask[1]) z_next = I_alu_zero;
            if (I_alu_mask[2]) v_next = I_alu_overflow;
            if (I_alu_mask[3]) n_next = I_alu_sign;
            // Flag instructions are applied after the ALU so they win on the same flag.
            case (I_flag_op)
                3'd1:    c_next = 1'b0;
                3'd2:    c_next = 1'b1;
                3'd3:    i_next = 1'b0;
                3'd4:    i_next = 1'b1;
                3'd5:    v_next = 1'b0;
                3'd6:    d_next = 1'b0;
                3'd7:    d_next = 1'b1;
                default: ;
            endcase
        end
        if (I_set_i) i_next = 1'b1;
    end

`ifdef CORE_IRQ_DELAY_EN
    assign i_gate = flag_i;
`else
    assign i_gate = i_next;
`endif

    assign nmi_fell = nmi_prev & ~I_nmi_n;
    assign poll_ok  = I_poll & ~int_request;
    assign take_nmi = poll_ok & nmi_pending;
    assign take_irq = poll_ok & ~nmi_pending & irq_level & ~i_gate;

    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            flag_c      <= 1'b0;
            flag_z      <= 1'b0;
            flag_i      <= 1'b1;
            flag_d      <= 1'b0;
            flag_v      <= 1'b0;
            flag_n      <= 1'b0;
            nmi_prev    <= 1'b1;
            nmi_pending <= 1'b0;
            irq_level   <= 1'b0;
            int_request <= 1'b0;
            int_is_nmi  <= 1'b0;
        end else if (I_enable) begin
            flag_c    <= c_next;
            flag_z    <= z_next;
            flag_i    <= i_next;
            flag_d    <= d_next;
            flag_v    <= v_next;
            flag_n    <= n_next;
            nmi_prev  <= I_nmi_n;
            irq_level <= ~I_irq_n;
            // A fresh edge during the NMI ack cycle must survive the clear.
            if (nmi_fell)
                nmi_pending <= 1'b1;
            else if (I_int_ack && int_request && int_is_nmi)
                nmi_pending <= 1'b0;
            if (take_nmi || take_irq) begin
                int_request <= 1'b1;
                int_is_nmi  <= take_nmi;
            end else if (I_int_ack) begin
                int_request <= 1'b0;
                int_is_nmi  <= 1'b0;
            end
        end
    end

    assign O_p           = {flag_n, flag_v, 1'b1, 1'b0, flag_d, flag_i, flag_z, flag_c};
    assign O_push_data   = {flag_n, flag_v, 1'b1, I_brk, flag_d, flag_i, flag_z, flag_c};
    assign O_carry       = flag_c;
    assign O_zero        = flag_z;
    assign O_overflow    = flag_v;
    assign O_sign        = flag_n;
    assign O_int_request = int_request;
    assign O_int_is_nmi  = int_is_nmi;

endmodule

// File: tb/tb_core_status.sv
// Bench for core_status: directed scenarios then random traffic against a byte-level model.
module tb_core_status;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable, alu_carry, alu_zero, alu_overflow, alu_sign;
    logic [3:0] alu_mask;
    logic [2:0] flag_op;
    logic       load_p, set_i, brk, nmi_n, irq_n, poll, int_ack;
    logic [7:0] data;
    logic [7:0] p, push_data;
    logic       carry, zero, overflow, sign, int_request, int_is_nmi;

    core_status dut (
        .I_clock(clock), .I_reset_n(reset_n), .I_enable(enable),
        .I_alu_carry(alu_carry), .I_alu_zero(alu_zero),
        .I_alu_overflow(alu_overflow), .I_alu_sign(alu_sign),
        .I_alu_mask(alu_mask), .I_flag_op(flag_op), .I_load_p(load_p),
        .I_data(data), .I_set_i(set_i), .I_brk(brk), .I_nmi_n(nmi_n),
        .I_irq_n(irq_n), .I_poll(poll), .I_int_ack(int_ack),
        .O_p(p), .O_push_data(push_data), .O_carry(carry), .O_zero(zero),
        .O_overflow(overflow), .O_sign(sign), .O_int_request(int_request),
        .O_int_is_nmi(int_is_nmi)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state: P kept as a whole byte, interrupt bookkeeping as plain bits.
    logic [7:0] m_p;
    logic       m_prev, m_pend, m_irq, m_req, m_nmi;
    logic [7:0] exp_q[$];
    int         op_pos[8] = '{0, 0, 0, 2, 2, 6, 3, 3};
    logic       op_val[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_p = 8'h24; m_prev = 1'b1; m_pend = 1'b0; m_irq = 1'b0;
        m_req = 1'b0; m_nmi = 1'b0;
        exp_q.delete();
    endtask

    task automatic idle();
        enable = 1'b1; alu_carry = 1'b0; alu_zero = 1'b0; alu_overflow = 1'b0;
        alu_sign = 1'b0; alu_mask = 4'd0; flag_op = 3'd0; load_p = 1'b0;
        data = 8'd0; set_i = 1'b0; brk = 1'b0; poll = 1'b0; int_ack = 1'b0;
    endtask

    task automatic compare_all();
        logic [7:0] exp_p;
        exp_p = exp_q.pop_front();
        check("p", p, exp_p);
        check("flags", {sign, overflow, zero, carry}, {exp_p[7], exp_p[6], exp_p[1], exp_p[0]});
        check("push", push_data, (exp_p & 8'hEF) | {3'b000, brk, 4'b0000});
        check("req", int_request, m_req);
        check("is_nmi", int_is_nmi, m_nmi);
    endtask

    // Predict from current inputs, clock once, then compare just after the edge.
    task automatic step();
        logic [7:0] pn, mb, ab;
        logic       gate, rn, nn, pend;
        if (enable) begin
            pn = m_p;
            if (load_p) begin
                pn = (data & 8'hCF) | 8'h20;
            end else begin
                mb = {alu_mask[3], alu_mask[2], 4'b0000, alu_mask[1], alu_mask[0]};
                ab = {alu_sign, alu_overflow, 4'b0000, alu_zero, alu_carry};
                pn = (pn & ~mb) | (ab & mb);
                if (flag_op != 3'd0) pn[op_pos[flag_op]] = op_val[flag_op];
            end
            if (set_i) pn[2] = 1'b1;
`ifdef CORE_IRQ_DELAY_EN
            gate = m_p[2];
`else
            gate = pn[2];
`endif
            rn = m_req; nn = m_nmi; pend = m_pend;
            if (int_ack && m_req) begin
                rn = 1'b0; nn = 1'b0;
                if (m_nmi) pend = 1'b0;
            end
            if (poll && !m_req) begin
                if (m_pend) begin rn = 1'b1; nn = 1'b1; end
                else if (m_irq && !gate) begin rn = 1'b1; nn = 1'b0; end
            end
            if (m_prev && !nmi_n) pend = 1'b1;
            m_p = pn; m_req = rn; m_nmi = nn; m_pend = pend;
            m_prev = nmi_n; m_irq = !irq_n;
        end
        exp_q.push_back(m_p);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    initial begin
        idle();
        nmi_n = 1'b1; irq_n = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_p", p, 8'h24);
        check("rst_req", int_request, 1'b0);
        check("rst_flags", {sign, overflow, zero, carry}, 4'h0);
        brk = 1'b1;
        #1;
        check("rst_push_brk", push_data, 8'h34);
        reset_n = 1'b1;
        brk = 1'b0;

        alu_mask = 4'b1010; {alu_carry, alu_zero, alu_overflow, alu_sign} = 4'hF;
        step(); check("alu_mask", p, 8'hA6);
        idle(); flag_op = 3'd2; alu_mask = 4'b0001; alu_carry = 1'b0;
        step(); check("sec_over_alu", p, 8'hA7);
        idle(); load_p = 1'b1; data = 8'hFF;
        step(); check("plp_ff", p, 8'hEF);
        data = 8'h00; set_i = 1'b1;
        step(); check("plp_set_i", p, 8'h24);

        idle(); flag_op = 3'd3; irq_n = 1'b0;
        step();
        idle(); poll = 1'b1;
        step(); check("irq_req", {int_request, int_is_nmi}, 2'b10);
        idle(); int_ack = 1'b1; irq_n = 1'b1;
        step(); check("irq_ack", int_request, 1'b0);
        idle(); step();

        nmi_n = 1'b0; step();
        poll = 1'b1; step(); check("nmi_req", {int_request, int_is_nmi}, 2'b11);
        idle(); int_ack = 1'b1; step(); check("nmi_ack", int_request, 1'b0);
        idle(); poll = 1'b1; step(); check("nmi_no_retrigger", int_request, 1'b0);
        idle(); nmi_n = 1'b1; step();

        flag_op = 3'd4; step();
        idle(); irq_n = 1'b0; step();
        poll = 1'b1; flag_op = 3'd3; step();
`ifdef CORE_IRQ_DELAY_EN
        check("cli_delay_now", int_request, 1'b0);
        idle(); poll = 1'b1; step();
        check("cli_delay_next", int_request, 1'b1);
`else
        check("cli_same_poll", int_request, 1'b1);
`endif
        idle(); int_ack = 1'b1; irq_n = 1'b1; step();
        idle(); step();

        for (int n = 0; n < 3000; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            {alu_carry, alu_zero, alu_overflow, alu_sign} = 4'($urandom_range(0, 15));
            alu_mask = 4'($urandom_range(0, 15));
            flag_op = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            load_p = ($urandom_range(0, 9) == 0);
            data = 8'($urandom_range(0, 255));
            set_i = ($urandom_range(0, 14) == 0);
            brk = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(0, 5) == 0) irq_n = ~irq_n;
            poll = ($urandom_range(0, 2) == 0);
            int_ack = m_req && ($urandom_range(0, 2) == 0);
            if (n == 1500) begin
                reset_n = 1'b0;
                #2;
                model_reset();
                check("mid_rst_req", {int_request, int_is_nmi}, 2'b00);
                check("mid_rst_p", p, 8'h24);
                @(posedge clock);
                #1;
                reset_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
